tl_phase_scheduler: RTL
=======================

TL_PHASE_SCHEDULER -- requirements
Module: tl_phase_scheduler

Interface
REQ-001 Parameter YELLOW_CYC, default 3: cycles spent in each yellow phase (range 1..31).
REQ-002 Parameter MIN_GREEN, default 4: minimum cycles in any go phase (range 1..31).
REQ-003 Parameter MAX_GREEN, default 12: maximum cycles in any go phase (range MIN_GREEN..31).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 Ta, Tb  input  1 each  through-traffic sensors for streets A and B.
REQ-007 Tal, Tbl  input  1 each  left-turn sensors for streets A and B.
REQ-008 La, Lb  output  2 each  light codes: 00 green, 01 yellow, 10 red, 11 left arrow.
REQ-009 state  output  3  current phase encoding.
REQ-010 phase_start  output  1  one-cycle pulse in the first cycle of every phase.

Function
REQ-011 Phases SHALL be: 000 A_GO, 001 A_YEL, 010 AL_GO, 011 AL_YEL, 100 B_GO, 101 B_YEL, 110 BL_GO, 111 BL_YEL.
REQ-012 The phase timer SHALL be 5 bits, clear to 0 on each phase change, and increment each cycle otherwise, saturating at 31.
REQ-013 Go-phase exit: a go phase SHALL leave at the clock edge where timer >= MIN_GREEN-1 and (own sensor low or timer >= MAX_GREEN-1); own sensor is Ta/Tal/Tb/Tbl for A_GO/AL_GO/B_GO/BL_GO.
REQ-014 Go-phase successors: A_GO->A_YEL, AL_GO->AL_YEL, B_GO->B_YEL, BL_GO->BL_YEL.
REQ-015 A yellow phase SHALL leave at the edge where timer == YELLOW_CYC-1.
REQ-016 Yellow-phase successors: A_YEL->AL_GO if req_al else B_GO; AL_YEL->B_GO; B_YEL->BL_GO if req_bl else A_GO; BL_YEL->A_GO.
REQ-017 req_al SHALL be set by Tal=1 in any phase other than AL_GO, and cleared on the edge entering AL_GO; clear wins over simultaneous set.
REQ-018 req_bl SHALL behave identically, using Tbl and BL_GO.
REQ-019 Tal/Tbl high during AL_GO/BL_GO SHALL only extend that phase (REQ-013), never set the latch.
REQ-020 Light mapping (La,Lb): A_GO 00,10; A_YEL 01,10; AL_GO 11,10; AL_YEL 01,10; B_GO 10,00; B_YEL 10,01; BL_GO 10,11; BL_YEL 10,01.
REQ-021 La, Lb, state SHALL be registered outputs, decoded from the current phase with no input-to-output combinational path.
REQ-022 phase_start SHALL be 1 in the first cycle after reset release and in the first cycle of every new phase, else 0.
REQ-023 No sensor combination SHALL make both streets non-red at once.

Reset
REQ-024 On reset: state=000, timer=0, req_al=req_bl=0, La=00, Lb=10, phase_start=0; effective immediately, mid-phase included.
REQ-025 On the first edge after reset deassertion, phase_start SHALL be 1 and A_GO timing SHALL begin from timer=0.

Structure
REQ-026 Shared package tl_pkg SHALL hold the phase encodings, light codes and parameter defaults.
REQ-027 Timer SHALL be sub-module tl_phase_timer (clear, enable, saturating 5-bit count).
REQ-028 The next-phase decision SHALL be a pure combinational block inside tl_phase_scheduler.

Verification (defaults 3/4/12)
REQ-029 Reset, all sensors 0 -> A_GO 4 cyc, A_YEL 3, B_GO 4, B_YEL 3, then A_GO; left phases skipped.
REQ-030 Ta held 1 -> A_GO held exactly 12 cycles, then A_YEL with La=01.
REQ-031 One-cycle Tal pulse in A_GO -> after A_YEL, AL_GO for 4 cyc with La=11, then AL_YEL 3 cyc, then B_GO; req_al=0 after AL_GO entry.
REQ-032 Tbl high only in the B_YEL->BL_GO entry cycle -> req_bl cleared, single BL_GO of 4 cyc, A_GO follows without a second BL_GO.
REQ-033 Reset asserted in A_YEL timer=1 -> same cycle state=000, La=00, Lb=10; A_GO lasts 4 cyc after release.
REQ-034 Random sensors, 10000 cycles -> REQ-023 always holds; phase_start count equals phase-change count plus one.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared phase encodings, light codes and timing defaults for the
// two-street traffic-light phase scheduler.
package tl_pkg;

    typedef enum logic [2:0] {
        A_GO   = 3'b000,
        A_YEL  = 3'b001,
        AL_GO  = 3'b010,
        AL_YEL = 3'b011,
        B_GO   = 3'b100,
        B_YEL  = 3'b101,
        BL_GO  = 3'b110,
        BL_YEL = 3'b111
    } phase_t;

    typedef enum logic [1:0] {
        LT_GREEN  = 2'b00,
        LT_YELLOW = 2'b01,
        LT_RED    = 2'b10,
        LT_LEFT   = 2'b11
    } light_t;

    localparam int YELLOW_CYC_DEF = 3;
    localparam int MIN_GREEN_DEF  = 4;
    localparam int MAX_GREEN_DEF  = 12;
    localparam int TIMER_W        = 5;

    // Returns {La, Lb}; every phase keeps at least one street red.
    function automatic logic [3:0] phase_lights(phase_t p);
        logic [3:0] l;
        l = {LT_GREEN, LT_RED};
        case (p)
            A_GO:    l = {LT_GREEN,  LT_RED};
            A_YEL:   l = {LT_YELLOW, LT_RED};
            AL_GO:   l = {LT_LEFT,   LT_RED};
            AL_YEL:  l = {LT_YELLOW, LT_RED};
            B_GO:    l = {LT_RED,    LT_GREEN};
            B_YEL:   l = {LT_RED,    LT_YELLOW};
            BL_GO:   l = {LT_RED,    LT_LEFT};
            BL_YEL:  l = {LT_RED,    LT_YELLOW};
            default: l = {LT_GREEN,  LT_RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Per-phase cycle counter: synchronous clear, count enable, saturates at
// the top of its 5-bit range.
module tl_phase_timer
    import tl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [TIMER_W-1:0] count
);

    localparam logic [TIMER_W-1:0] COUNT_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != COUNT_MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tl_phase_scheduler.sv
// Eight-phase traffic-light scheduler: through and left-turn phases for two
// streets, sensor-extended go phases and latched left-turn requests.
module tl_phase_scheduler
    import tl_pkg::*;
#(
    parameter int YELLOW_CYC = YELLOW_CYC_DEF,
    parameter int MIN_GREEN  = MIN_GREEN_DEF,
    parameter int MAX_GREEN  = MAX_GREEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       Tal,
    input  logic       Tbl,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [2:0] state,
    output logic       phase_start
);

    localparam logic [TIMER_W-1:0] MIN_LAST = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] MAX_LAST = TIMER_W'(MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST = TIMER_W'(YELLOW_CYC - 1);

    phase_t             phase_q, phase_d;
    logic [TIMER_W-1:0] timer;
    logic               started;
    logic               req_al, req_bl;
    logic               req_al_d, req_bl_d;
    logic               own_sensor;
    logic               leave;

    // The first edge after reset only arms the scheduler, so A_GO timing
    // starts from zero in the cycle that carries the phase_start pulse.
    tl_phase_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!started || leave),
        .enable (1'b1),
        .count  (timer)
    );

    always_comb begin
        phase_d    = phase_q;
        leave      = 1'b0;
        own_sensor = 1'b0;
        req_al_d   = req_al;
        req_bl_d   = req_bl;

        case (phase_q)
            A_GO:    own_sensor = Ta;
            AL_GO:   own_sensor = Tal;
            B_GO:    own_sensor = Tb;
            BL_GO:   own_sensor = Tbl;
            default: own_sensor = 1'b0;
        endcase

        if (started) begin
            if (!phase_q[0]) begin
                leave = (timer >= MIN_LAST) && (!own_sensor || timer >= MAX_LAST);
            end else begin
                leave = (timer == YEL_LAST);
            end
        end

        if (leave) begin
            case (phase_q)
                A_GO:    phase_d = A_YEL;
                A_YEL:   phase_d = req_al ? AL_GO : B_GO;
                AL_GO:   phase_d = AL_YEL;
                AL_YEL:  phase_d = B_GO;
                B_GO:    phase_d = B_YEL;
                B_YEL:   phase_d = req_bl ? BL_GO : A_GO;
                BL_GO:   phase_d = BL_YEL;
                BL_YEL:  phase_d = A_GO;
                default: phase_d = A_GO;
            endcase
        end

        // Entering the left phase consumes the request even if the sensor
        // is still high on that same edge.
        if (leave && phase_d == AL_GO) begin
            req_al_d = 1'b0;
        end else if (Tal && phase_q != AL_GO) begin
            req_al_d = 1'b1;
        end

        if (leave && phase_d == BL_GO) begin
            req_bl_d = 1'b0;
        end else if (Tbl && phase_q != BL_GO) begin
            req_bl_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= A_GO;
            started     <= 1'b0;
            req_al      <= 1'b0;
            req_bl      <= 1'b0;
            La          <= LT_GREEN;
            Lb          <= LT_RED;
            phase_start <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            started     <= 1'b1;
            req_al      <= req_al_d;
            req_bl      <= req_bl_d;
            {La, Lb}    <= phase_lights(phase_d);
            phase_start <= !started || leave;
        end
    end

    assign state = phase_q;

endmodule
